// File: rtl/vrf_write_arbiter.sv
// vrf_write_arbiter: shares the vector register file write port between
// pipeline writeback (priority, never stalled) and an auxiliary loader that
// is buffered in a small FIFO. Also flags decode read hazards against pending
// aux entries and raises a starvation request when the FIFO head waits too long.
// Optional feature: define VRF_ARB_BYPASS_EN to let an aux request write
// straight through when the FIFO is empty and the port is idle.
module vrf_write_arbiter #(
  parameter int V        = 256,
  parameter int R        = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         RegWriteVW,
  input  logic [R-1:0] WA3W,
  input  logic [V-1:0] ResultVW,
  input  logic         aux_valid,
  output logic         aux_ready,
  input  logic [R-1:0] aux_addr,
  input  logic [V-1:0] aux_data,
  input  logic [R-1:0] RA1D,
  input  logic [R-1:0] RA2D,
  output logic         PendHitD,
  output logic         StarveReq,
  output logic         VWE3,
  output logic [R-1:0] VA3,
  output logic [V-1:0] VWD3
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, STARVE} state_t;

  logic [R-1:0]  addr_mem_q [DEPTH];
  logic [R-1:0]  addr_mem_d [DEPTH];
  logic [V-1:0]  data_mem_q [DEPTH];
  logic [V-1:0]  data_mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  state_t        state_q, state_d;

  logic empty, push, pop, byp;

  // Handshake and FIFO control; ready is forced low while reset is held
  always_comb begin
    empty     = (count_q == '0);
    aux_ready = rst & (count_q < CW'(DEPTH));
`ifdef VRF_ARB_BYPASS_EN
    byp       = aux_valid & aux_ready & empty & ~RegWriteVW;
`else
    byp       = 1'b0;
`endif
    pop       = ~RegWriteVW & ~empty;
    push      = aux_valid & aux_ready & ~byp;
  end

  // Write port mux: pipeline first, then FIFO head, then (optional) bypass
  always_comb begin
    VWE3 = 1'b0;
    VA3  = '0;
    VWD3 = '0;
    if (RegWriteVW) begin
      VWE3 = 1'b1;
      VA3  = WA3W;
      VWD3 = ResultVW;
    end else if (!empty) begin
      VWE3 = 1'b1;
      VA3  = addr_mem_q[rd_ptr_q];
      VWD3 = data_mem_q[rd_ptr_q];
    end else if (byp) begin
      VWE3 = 1'b1;
      VA3  = aux_addr;
      VWD3 = aux_data;
    end
  end

  // Decode hazard: any occupied slot (including one popping now) matching a read
  always_comb begin
    PendHitD = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (addr_mem_q[rd_ptr_q + PW'(i)] == RA1D ||
            addr_mem_q[rd_ptr_q + PW'(i)] == RA2D)
          PendHitD = 1'b1;
      end
    end
  end

  // Next-state: storage, pointers, occupancy, head wait counter, FSM
  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = aux_addr;
      data_mem_d[wr_ptr_q] = aux_data;
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    // head present and not popping can only mean it lost to writeback
    wait_d = wait_q;
    if (pop || empty)                wait_d = '0;
    else if (wait_q != WW'(MAX_WAIT)) wait_d = wait_q + 1'b1;

    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = DRAIN;
      DRAIN: begin
        if (count_d == '0)                state_d = IDLE;
        else if (wait_d == WW'(MAX_WAIT)) state_d = STARVE;
      end
      STARVE:  if (pop) state_d = (count_d == '0) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  assign StarveReq = (state_q == STARVE);

  // State registers; reset drops every pending aux entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      state_q  <= IDLE;
    end else begin
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Bench for vrf_write_arbiter: vector table, directed corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_vrf_write_arbiter;

  localparam int V = 256, R = 5, DEPTH = 4, MAX_WAIT = 8;
`ifdef VRF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk, rst, RegWriteVW, aux_valid, aux_ready;
  logic [R-1:0] WA3W, aux_addr, RA1D, RA2D, VA3;
  logic [V-1:0] ResultVW, aux_data, VWD3;
  logic         PendHitD, StarveReq, VWE3;

  vrf_write_arbiter #(.V(V), .R(R), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .RegWriteVW(RegWriteVW), .WA3W(WA3W), .ResultVW(ResultVW),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .RA1D(RA1D), .RA2D(RA2D), .PendHitD(PendHitD), .StarveReq(StarveReq),
    .VWE3(VWE3), .VA3(VA3), .VWD3(VWD3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [R-1:0] a; logic [V-1:0] d; } ent_t;
  ent_t mq[$];
  int   wm;
  bit   starve_m;

  int n_cmp = 0, n_bad = 0;
  logic         s_we, s_rdy, s_pend, s_stv;
  logic [R-1:0] s_va;

  typedef struct {
    logic rw; logic [R-1:0] wa; logic av; logic [R-1:0] aa;
    logic [R-1:0] r1, r2;
    logic e_we; logic [R-1:0] e_va; logic e_rdy, e_pend;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [V-1:0] act, input logic [V-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive, compare mid-cycle against the model, advance model
  task automatic cyc(input logic r, input logic rw, input logic [R-1:0] wa,
                     input logic av, input logic [R-1:0] aa, input logic [V-1:0] ad,
                     input logic [R-1:0] r1, input logic [R-1:0] r2);
    logic [V-1:0] pd, e_d;
    logic [R-1:0] e_a;
    logic e_we, e_rdy, e_byp, e_pend;
    bit had, popped, pushed;
    pd = {8{$urandom}};
    rst = r; RegWriteVW = rw; WA3W = wa; ResultVW = pd;
    aux_valid = av; aux_addr = aa; aux_data = ad; RA1D = r1; RA2D = r2;
    #4;
    if (!r) begin mq.delete(); wm = 0; starve_m = 0; end
    e_rdy = r && (mq.size() < DEPTH);
    e_byp = BYP && e_rdy && av && (mq.size() == 0) && !rw;
    e_we = 1'b0; e_a = '0; e_d = '0;
    if (rw)                 begin e_we = 1'b1; e_a = wa;       e_d = pd;       end
    else if (mq.size() > 0) begin e_we = 1'b1; e_a = mq[0].a;  e_d = mq[0].d;  end
    else if (e_byp)         begin e_we = 1'b1; e_a = aa;       e_d = ad;       end
    e_pend = 1'b0;
    foreach (mq[i]) if (mq[i].a == r1 || mq[i].a == r2) e_pend = 1'b1;
    s_we = VWE3; s_va = VA3; s_rdy = aux_ready; s_pend = PendHitD; s_stv = StarveReq;
    chk("model_vwe3", VWE3, e_we);
    chk("model_va3", VA3, e_a);
    chk("model_vwd3", VWD3, e_d);
    chk("model_aux_ready", aux_ready, e_rdy);
    chk("model_pendhit", PendHitD, e_pend);
    chk("model_starve", StarveReq, starve_m);
    @(posedge clk);
    if (r) begin
      had    = mq.size() > 0;
      popped = !rw && had;
      pushed = av && e_rdy && !e_byp;
      if (popped) void'(mq.pop_front());
      if (pushed) mq.push_back('{a: aa, d: ad});
      if (popped || !had) wm = 0;
      else if (wm < MAX_WAIT) wm = wm + 1;
      starve_m = (wm == MAX_WAIT);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, '0, 31, 31);
  endtask

  initial begin
    rst = 0; RegWriteVW = 0; WA3W = 0; ResultVW = '0; aux_valid = 1;
    aux_addr = 0; aux_data = '0; RA1D = 0; RA2D = 0;
    wm = 0; starve_m = 0;
    //           rw  wa  av aa  r1  r2 | we va rdy pend
    tbl[0] = '{1'b1, 7, 1'b1, 2, 0, 0, 1'b1, 7, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 7, 1'b0, 0, 2, 0, 1'b1, 7, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 0, 1'b0, 0, 0, 2, 1'b1, 2, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 0, 1'b0, 0, 0, 2, 1'b0, 0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1, 1'b1, 5, 5, 0, 1'b1, 1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 0, 1'b1, 6, 0, 5, 1'b1, 5, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 0, 1'b0, 0, 5, 6, 1'b1, 6, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 0, 1'b0, 0, 5, 6, 1'b0, 0, 1'b1, 1'b0};
    @(posedge clk); #1;

    // reset held with a valid aux request
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 4, {8{32'h1111_2222}}, 4, 4);
    chk("rst_vwe3", s_we, 1'b0);
    chk("rst_aux_ready", s_rdy, 1'b0);
    chk("rst_starve", s_stv, 1'b0);
    cyc(1, 0, 0, 0, 4, '0, 4, 4);
    chk("rel_aux_ready", s_rdy, 1'b1);
    chk("rel_vwe3", s_we, 1'b0);

    // table vectors
    for (int i = 0; i < 8; i++) begin
      cyc(1, tbl[i].rw, tbl[i].wa, tbl[i].av, tbl[i].aa, {8{32'hA5A5_0000 | i}},
          tbl[i].r1, tbl[i].r2);
      chk($sformatf("tbl%0d_vwe3", i), s_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_va3", i), s_va, tbl[i].e_va);
      chk($sformatf("tbl%0d_ready", i), s_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_pend", i), s_pend, tbl[i].e_pend);
    end

    // single aux request from idle: latency 1, or 0 with bypass
    cyc(1, 0, 0, 1, 3, {32{8'hA5}}, 31, 31);
    chk("single_k_vwe3", s_we, BYP);
    chk("single_k_va3", s_va, BYP ? 5'd3 : 5'd0);
    cyc(1, 0, 0, 0, 0, '0, 31, 31);
    chk("single_k1_vwe3", s_we, !BYP);
    chk("single_k1_va3", s_va, BYP ? 5'd0 : 5'd3);
    idle(1);

    // starvation: head blocked 8 cycles, flag visible in the 9th
    cyc(1, 1, 7, 1, 9, {8{32'h0000_0009}}, 31, 31);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 7, 0, 0, '0, 31, 31);
      chk($sformatf("starve_wait%0d", i), s_stv, 1'b0);
    end
    cyc(1, 1, 7, 0, 0, '0, 31, 31);
    chk("starve_set", s_stv, 1'b1);
    cyc(1, 0, 0, 0, 0, '0, 31, 31);
    chk("starve_pop_va3", s_va, 5'd9);
    chk("starve_pop_flag", s_stv, 1'b1);
    cyc(1, 0, 0, 0, 0, '0, 31, 31);
    chk("starve_clear", s_stv, 1'b0);
    chk("starve_empty_vwe3", s_we, 1'b0);

    // full FIFO: 5th request waits for the first pop, order preserved
    for (int i = 0; i < 4; i++) cyc(1, 1, 20, 1, 5'(i), {8{32'(i)}}, 31, 31);
    cyc(1, 1, 20, 1, 4, {8{32'd4}}, 31, 31);
    chk("full_ready", s_rdy, 1'b0);
    cyc(1, 0, 0, 1, 4, {8{32'd4}}, 31, 31);
    chk("full_pop_ready", s_rdy, 1'b0);
    chk("full_order0", s_va, 5'd0);
    cyc(1, 0, 0, 1, 4, {8{32'd4}}, 31, 31);
    chk("full_reopen_ready", s_rdy, 1'b1);
    chk("full_order1", s_va, 5'd1);
    for (int i = 2; i <= 4; i++) begin
      cyc(1, 0, 0, 0, 0, '0, 31, 31);
      chk($sformatf("full_order%0d", i), s_va, 5'(i));
    end
    idle(1);

    // reset in the middle of operation discards pending entries
    cyc(1, 1, 1, 1, 11, {8{32'hB}}, 31, 31);
    cyc(1, 1, 1, 1, 12, {8{32'hC}}, 31, 31);
    cyc(0, 0, 0, 0, 0, '0, 11, 12);
    chk("midrst_vwe3", s_we, 1'b0);
    chk("midrst_pend", s_pend, 1'b0);
    cyc(1, 0, 0, 0, 0, '0, 11, 12);
    chk("postrst_vwe3", s_we, 1'b0);
    chk("postrst_pend", s_pend, 1'b0);

    // randomized traffic with busy phases to provoke starvation
    for (int i = 0; i < 600; i++) begin
      int busy;
      busy = ((i / 50) % 2 == 1) ? 92 : 40;
      cyc($urandom_range(0, 99) != 0,
          $urandom_range(0, 99) < busy, 5'($urandom_range(0, 31)),
          $urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), {8{$urandom}},
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
